// File: rtl/fetch_unit.sv
// fetch_unit: PC generator, one-cycle imem request, DEPTH-entry fetch queue and optional delay-slot retention.
// Responses arrive the cycle after issue, so a redirect can drop an in-flight response in the cycle it lands.
module fetch_unit #(
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter int                 DEPTH      = 4,
    parameter bit                 DELAY_SLOT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      inst_req,
    output logic [ADDR_W-1:0]         inst_addr,
    input  logic [ADDR_W-1:0]         inst_rdata,
    output logic                      validD,
    output logic [ADDR_W-1:0]         instrD,
    output logic [ADDR_W-1:0]         pcD,
    output logic [ADDR_W-1:0]         pc_plus4D,
    input  logic                      stallD,
    input  logic                      branchD,
    input  logic [ADDR_W-1:0]         branch_target,
    input  logic                      jumpD,
    output logic [$clog2(DEPTH):0]    occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] q_instr [DEPTH];
    logic [ADDR_W-1:0] q_pc [DEPTH];
    logic [PW-1:0]     rptr, wptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] pc, req_pc, pend_target, target, jump_target;
    logic              inflight, pend_valid, pop, redirect_now, hold_slot, keep, flush, push;

    assign validD       = count != '0;
    assign instrD       = validD ? q_instr[rptr] : '0;
    assign pcD          = validD ? q_pc[rptr] : '0;
    assign pc_plus4D    = validD ? pcD + ADDR_W'(4) : '0;
    assign jump_target  = {pc_plus4D[ADDR_W-1:28], instrD[25:0], 2'b00};
    assign occupancy    = count;
    assign inst_addr    = pc;
    assign pop          = validD & ~stallD;
    assign redirect_now = pop & (branchD | jumpD);
    assign target       = branchD ? branch_target : jump_target;
    // Delay slot not yet fetched: park the target until the slot has been issued.
    assign hold_slot    = redirect_now & DELAY_SLOT & (count == CW'(1)) & ~inflight;
    assign keep         = DELAY_SLOT && count > CW'(1);
    assign flush        = redirect_now & (!DELAY_SLOT || count > CW'(1));
    assign push         = inflight & ~flush;
    assign inst_req     = ~rst & (count + CW'(inflight) < CW'(DEPTH)) & ~redirect_now;

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wptr] <= inst_rdata;
            q_pc[wptr]    <= req_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            req_pc      <= '0;
            pend_target <= '0;
            pend_valid  <= 1'b0;
            inflight    <= 1'b0;
            rptr        <= '0;
            wptr        <= '0;
            count       <= '0;
        end else begin
            inflight <= inst_req;
            if (inst_req)
                req_pc <= pc;
            rptr  <= rptr + PW'(pop);
            wptr  <= flush ? rptr + PW'(1) + PW'(keep) : wptr + PW'(push);
            count <= flush ? CW'(keep) : count + CW'(push) - CW'(pop);
            if (hold_slot) begin
                pend_valid  <= 1'b1;
                pend_target <= target;
            end else if (redirect_now) begin
                pc <= target;
            end else if (inst_req) begin
                pc         <= pend_valid ? pend_target : pc + ADDR_W'(4);
                pend_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with DELAY_SLOT=0 (index 0) and DELAY_SLOT=1 (index 1) side by side.
module tb_fetch_unit;
    logic        clk = 1'b0, rst = 1'b1, stallD = 1'b0, branchD = 1'b0, jumpD = 1'b0;
    logic [31:0] branch_target = '0, jaddr = '1;
    logic        req [2];
    logic        vd [2];
    logic [31:0] addr [2];
    logic [31:0] rdata [2];
    logic [31:0] instr [2];
    logic [31:0] pcd [2];
    logic [31:0] pp4 [2];
    logic [2:0]  occ [2];
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == jaddr ? 32'h0800_0040 : a ^ 32'hA5A5_0000;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fetch_unit #(.DELAY_SLOT(g == 1)) dut (
            .clk(clk), .rst(rst), .inst_req(req[g]), .inst_addr(addr[g]), .inst_rdata(rdata[g]),
            .validD(vd[g]), .instrD(instr[g]), .pcD(pcd[g]), .pc_plus4D(pp4[g]), .stallD(stallD),
            .branchD(branchD), .branch_target(branch_target), .jumpD(jumpD), .occupancy(occ[g])
        );
        always @(posedge clk) if (req[g]) rdata[g] <= mem(addr[g]);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; stallD = 1'b0; branchD = 1'b0; jumpD = 1'b0;
        step; step;
        rst = 1'b0;
    endtask

    initial begin
        // reset state
        step; step;
        for (int g = 0; g < 2; g++) begin
            chk("rst_valid", vd[g], 0); chk("rst_occ", occ[g], 0); chk("rst_req", req[g], 0);
            chk("rst_instr", instr[g], 0); chk("rst_pc", pcd[g], 0); chk("rst_pc4", pp4[g], 0);
        end
        // free run
        rst = 1'b0; #1;
        chk("fr_req0", req[1], 1); chk("fr_addr0", addr[1], 0);
        step; chk("fr_valid1", vd[1], 0); chk("fr_addr1", addr[1], 32'h4);
        step; chk("fr_valid2", vd[1], 1); chk("fr_pc2", pcd[1], 0);
        chk("fr_instr2", instr[1], 32'hA5A5_0000); chk("fr_pc4_2", pp4[1], 32'h4);
        step; chk("fr_pc3", pcd[1], 32'h4); chk("fr_instr3", instr[1], 32'hA5A5_0004);
        step; chk("fr_pc4", pcd[1], 32'h8); chk("fr_occ4", occ[1], 1);
        // stall fills the queue, release drains in order
        do_reset; stallD = 1'b1;
        repeat (10) step;
        chk("st_occ", occ[1], 4); chk("st_req", req[1], 0); chk("st_pc", pcd[1], 0); chk("st_valid", vd[1], 1);
        stallD = 1'b0;
        for (int i = 1; i <= 4; i++) begin step; chk("st_drain", pcd[1], 32'(4 * i)); end
        // branch from head 0x8 with count=3
        do_reset; stallD = 1'b1;
        repeat (8) step;
        stallD = 1'b0; step;
        stallD = 1'b1; step; step;
        stallD = 1'b0; step;
        chk("br_pre_occ", occ[1], 3); chk("br_pre_pc", pcd[1], 32'h8);
        branchD = 1'b1; branch_target = 32'h100; #1;
        chk("br_req_ds0", req[0], 0); chk("br_req_ds1", req[1], 0);
        step; branchD = 1'b0;
        chk("br1_valid_ds0", vd[0], 0); chk("br1_occ_ds0", occ[0], 0);
        chk("br1_pc_ds1", pcd[1], 32'hC); chk("br1_occ_ds1", occ[1], 1);
        chk("br1_addr_ds0", addr[0], 32'h100); chk("br1_addr_ds1", addr[1], 32'h100);
        step; chk("br2_valid_ds0", vd[0], 0); chk("br2_valid_ds1", vd[1], 0);
        step; chk("br3_pc_ds0", pcd[0], 32'h100); chk("br3_pc_ds1", pcd[1], 32'h100);
        step; chk("br4_pc_ds0", pcd[0], 32'h104); chk("br4_pc_ds1", pcd[1], 32'h104);
        // count=1 with nothing in flight: delay slot fetched after the redirect
        do_reset; stallD = 1'b1;
        repeat (8) step;
        stallD = 1'b0; step;
        branchD = 1'b1; branch_target = 32'hC;
        step;
        chk("pd1_pc_ds1", pcd[1], 32'h8); chk("pd1_occ_ds1", occ[1], 1); chk("pd1_addr_ds1", addr[1], 32'hC);
        chk("pd1_valid_ds0", vd[0], 0);
        branch_target = 32'h100; #1;
        chk("pd1_req_ds1", req[1], 0);
        step; branchD = 1'b0;
        chk("pd2_valid_ds1", vd[1], 0); chk("pd2_req_ds1", req[1], 1); chk("pd2_addr_ds1", addr[1], 32'hC);
        step; chk("pd3_addr_ds1", addr[1], 32'h100); chk("pd3_pc_ds0", pcd[0], 32'hC);
        step; chk("pd4_pc_ds1", pcd[1], 32'hC); chk("pd4_pc_ds0", pcd[0], 32'h10);
        step; chk("pd5_pc_ds1", pcd[1], 32'h100);
        // jump computed from instrD and pc_plus4D
        jaddr = 32'hC;
        do_reset;
        repeat (5) step;
        chk("jp_instr", instr[1], 32'h0800_0040); chk("jp_pc4", pp4[1], 32'h10);
        jumpD = 1'b1; #1;
        chk("jp_req", req[1], 0);
        step; jumpD = 1'b0;
        chk("jp_addr_ds0", addr[0], 32'h100); chk("jp_addr_ds1", addr[1], 32'h100);
        chk("jp_valid_ds0", vd[0], 0); chk("jp_slot_ds1", pcd[1], 32'h10);
        // branch wins over jump
        do_reset;
        repeat (5) step;
        jumpD = 1'b1; branchD = 1'b1; branch_target = 32'h200;
        step; jumpD = 1'b0; branchD = 1'b0;
        chk("bj_addr_ds0", addr[0], 32'h200); chk("bj_addr_ds1", addr[1], 32'h200);
        // reset mid-operation with a response in flight
        do_reset; stallD = 1'b1;
        repeat (4) step;
        chk("mr_occ", occ[1], 3);
        rst = 1'b1;
        step;
        chk("mr_valid", vd[1], 0); chk("mr_occ0", occ[1], 0); chk("mr_req", req[1], 0);
        rst = 1'b0; stallD = 1'b0; #1;
        chk("mr_addr", addr[1], 0); chk("mr_req1", req[1], 1);
        step; chk("mr_stale_occ", occ[1], 0); chk("mr_stale_valid", vd[1], 0);
        step; chk("mr_pc", pcd[1], 0); chk("mr_instr", instr[1], 32'hA5A5_0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the 5-stage pipeline.
- Replaces the bare PC register / PC+4 adder / branch mux / F-D register with four parts:
  - a PC generator that supports both branch and jump redirects;
  - a one-cycle synchronous instruction-memory request interface;
  - a DEPTH-entry fetch queue that decouples fetch from decode;
  - optional MIPS branch-delay-slot retention.
- Feeds instrD / pc_plus4D to the decode stage.

Parameters:
- ADDR_W, 32, PC and instruction width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 4, fetch-queue entries. Must be a power of 2 and ≥2.
- DELAY_SLOT, 1. When 1, the instruction sequentially after a redirecting instruction is retained. When 0, it is discarded.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_req  out  1  instruction-memory read strobe.
- inst_addr  out  ADDR_W  read address; equals the current PC.
- inst_rdata  in  ADDR_W  read data, valid exactly one cycle after an accepted inst_req.
- validD  out  1  queue head is valid.
- instrD  out  ADDR_W  instruction at the queue head.
- pcD  out  ADDR_W  PC of the head instruction.
- pc_plus4D  out  ADDR_W  pcD+4.
- stallD  in  1  decode cannot accept; the head is popped when validD & ~stallD.
- branchD  in  1  redirect to branch_target.
- branch_target  in  ADDR_W  branch target address, computed by decode.
- jumpD  in  1  redirect to the jump target computed internally: {pc_plus4D[ADDR_W-1:28], instrD[25:0], 2'b00}.
- occupancy  out  $clog2(DEPTH)+1  number of valid queue entries.

Behaviour:
- Reset (rst=1 at an edge):
  - pc←RESET_PC;
  - queue cleared (read pointer = write pointer = 0, count = 0);
  - in-flight flag, discard flag and pending-target register cleared.
  - Outputs during and immediately after reset: validD=0, occupancy=0, inst_req=0, instrD/pcD/pc_plus4D=0.
  - Reset asserted mid-operation overrides every other event in that cycle.
- Issue rule:
  - inst_req = ~rst & (count + inflight < DEPTH) & ~redirect_now.
  - On issue: inflight←1 and pc←pc+4 (wraps modulo 2^ADDR_W). If a pending target is held, pc←pending_target instead and the pending target is cleared.
- Response:
  - In the cycle after an issue, inst_rdata is pushed as {instr, pc_of_request} unless the discard flag is set. A discarded response is dropped and the discard flag cleared.
  - A pushed entry becomes visible at the head the cycle after the push; the queue has no bypass.
- Simultaneous push and pop: allowed, count unchanged. The credit rule in the issue condition guarantees the queue never overflows.
- Full queue: inst_req=0 and pc holds.
- Empty queue: validD=0 and stallD is ignored.
- Redirect qualification:
  - redirect_now = validD & ~stallD & (branchD | jumpD).
  - branchD/jumpD are ignored when the head is not popped; decode must hold them until the pop.
  - If both are set, branchD wins.
- Redirect, DELAY_SLOT=0:
  - the head pops normally;
  - every other queue entry is flushed (count←0);
  - any in-flight response is discarded;
  - pc←target.
  - Timing: redirect at cycle t → target issued at t+1 → data at t+2 → validD with pcD=target at t+3.
- Redirect, DELAY_SLOT=1: the next sequential instruction (pcD+4) is kept, everything after it is flushed. The kept instruction is chosen as follows:
  - count≥2: keep entry head+1 (count←1); discard any in-flight response; pc←target.
  - count=1 and a response is in flight: keep that response (it is pushed); pc←target.
  - count=1 and nothing in flight: pending_target←target; the next issue fetches pc (the delay slot), then pc←pending_target.
- Stall (stallD=1): the head holds and outputs are stable. Fetch continues until the queue is full.
- Pointer arithmetic: pointers are $clog2(DEPTH) bits and wrap naturally. occupancy equals count.

Test Plan:
- Reset then free-run with stallD=0 and memory returning instr=addr^32'hA5A5_0000 → inst_addr sequence 0,4,8,…; first validD at cycle 3 after reset release with pcD=0; then one instruction per cycle; pc_plus4D=pcD+4.
- Hold stallD=1 for 10 cycles → occupancy rises to 4 and holds; inst_req=0 once count+inflight=4; head stays pcD=0. Release → pcD 0,4,8,C,10 in consecutive cycles with no gap or duplicate.
- DELAY_SLOT=0, branchD=1 with branch_target=0x100 while head pcD=0x8 pops and count=3 → next entries seen are pcD=0x100,0x104; pcs 0xC and 0x10 never appear at the head; validD=0 for exactly 2 cycles.
- DELAY_SLOT=1, same stimulus → next head pcD=0xC, then 0x100. Repeat with count=1 and no response in flight → head sequence 0x8, 0xC, 0x100.
- jumpD=1 with instrD=32'h0800_0040 and pc_plus4D=0x0000_0010 → redirect to 0x100. Assert branchD and jumpD together with branch_target=0x200 → target 0x200.
- rst pulsed while occupancy=3 with a response in flight → next cycle validD=0, occupancy=0; fetch restarts at RESET_PC; the stale response is never pushed.
